// File: rtl/vend_pkg.sv
// Shared types for the vending controller: FSM state encoding, coin codes and coin values.
package vend_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCollect = 3'd1,
        StVend    = 3'd2,
        StChange  = 3'd3,
        StRefund  = 3'd4
    } vend_state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_5    = 2'b11;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  return 3'd1;
            COIN_2:  return 3'd2;
            COIN_5:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_fsm_param_if.sv
// Button-side request signals and display/dispenser-side strobes of the vending controller.
interface vend_fsm_param_if #(
    parameter int unsigned CREDIT_W = 4
);
    logic [1:0]          coin;
    logic                item_sel;
    logic                buy;
    logic                cancel;
    logic                vend;
    logic                item_out;
    logic [CREDIT_W-1:0] change;
    logic                change_vld;
    logic                coin_rej;
    logic                nack;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output coin, item_sel, buy, cancel,
        input  vend, item_out, change, change_vld, coin_rej, nack, credit
    );

    modport slave (
        input  coin, item_sel, buy, cancel,
        output vend, item_out, change, change_vld, coin_rej, nack, credit
    );
endinterface

// File: rtl/vend_timeout.sv
// Idle counter for the vending controller: expires after TIMEOUT_CYC quiet cycles while running.
module vend_timeout #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic clk_slow,
    input  logic clr,
    input  logic run,
    input  logic kick,
    output logic expire
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expire = run && !kick && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (!run || kick || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_slow or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised two-item vending controller with saturating credit and change/refund strobes.
// Define VEND_TIMEOUT_EN to auto-refund credit after TIMEOUT_CYC idle cycles in COLLECT.
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W    = 4,
    parameter int unsigned PRICE_A     = 3,
    parameter int unsigned PRICE_B     = 4,
    parameter int unsigned MAX_CREDIT  = 9,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input logic             clk_slow,
    input logic             clr,
    vend_fsm_param_if.slave bus
);
    localparam logic [CREDIT_W:0] PriceAW = (CREDIT_W + 1)'(PRICE_A);
    localparam logic [CREDIT_W:0] PriceBW = (CREDIT_W + 1)'(PRICE_B);
    localparam logic [CREDIT_W:0] MaxCrW  = (CREDIT_W + 1)'(MAX_CREDIT);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                vend_q, vend_d;
    logic                item_q, item_d;
    logic                change_vld_q, change_vld_d;
    logic                coin_rej_q, coin_rej_d;
    logic                nack_q, nack_d;

    logic                coin_in;
    logic                expire;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W:0]   price_sel;

    assign coin_in   = (bus.coin != COIN_NONE);
    assign coin_sum  = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(bus.coin));
    assign price_sel = bus.item_sel ? PriceBW : PriceAW;

`ifdef VEND_TIMEOUT_EN
    logic to_run, to_kick;
    assign to_run  = (state_q == StCollect);
    assign to_kick = coin_in | bus.buy | bus.cancel;

    vend_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_slow(clk_slow),
        .clr     (clr),
        .run     (to_run),
        .kick    (to_kick),
        .expire  (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        change_d     = '0;
        vend_d       = 1'b0;
        item_d       = 1'b0;
        change_vld_d = 1'b0;
        nack_d       = 1'b0;
        // Any coin is returned unless the accept branch below takes it.
        coin_rej_d   = coin_in;
        case (state_q)
            StIdle, StCollect: begin
                if (expire || (bus.cancel && credit_q != '0)) begin
                    state_d      = StRefund;
                    change_d     = credit_q;
                    change_vld_d = 1'b1;
                    credit_d     = '0;
                end else if (bus.cancel) begin
                    state_d = StIdle;
                end else if (bus.buy) begin
                    if ({1'b0, credit_q} >= price_sel) begin
                        state_d  = StVend;
                        credit_d = credit_q - price_sel[CREDIT_W-1:0];
                        vend_d   = 1'b1;
                        item_d   = bus.item_sel;
                    end else begin
                        nack_d = 1'b1;
                    end
                end else if (coin_in && coin_sum <= MaxCrW) begin
                    state_d    = StCollect;
                    credit_d   = coin_sum[CREDIT_W-1:0];
                    coin_rej_d = 1'b0;
                end
            end
            StVend: begin
                if (credit_q != '0) begin
                    state_d      = StChange;
                    change_d     = credit_q;
                    change_vld_d = 1'b1;
                    credit_d     = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_slow or posedge clr) begin
        if (clr) begin
            state_q      <= StIdle;
            credit_q     <= '0;
            change_q     <= '0;
            vend_q       <= 1'b0;
            item_q       <= 1'b0;
            change_vld_q <= 1'b0;
            coin_rej_q   <= 1'b0;
            nack_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            change_q     <= change_d;
            vend_q       <= vend_d;
            item_q       <= item_d;
            change_vld_q <= change_vld_d;
            coin_rej_q   <= coin_rej_d;
            nack_q       <= nack_d;
        end
    end

    assign bus.vend       = vend_q;
    assign bus.item_out   = item_q;
    assign bus.change     = change_q;
    assign bus.change_vld = change_vld_q;
    assign bus.coin_rej   = coin_rej_q;
    assign bus.nack       = nack_q;
    assign bus.credit     = credit_q;
endmodule

// File: tb/tb_vend_fsm_param.sv
// Scoreboard bench for vend_fsm_param: directed scenarios plus random traffic against a
// transaction-level model of credit, sales, change and refunds.
module tb_vend_fsm_param;
    localparam int CW = 4, PA = 3, PB = 4, MAXC = 9, TO = 15;

    logic clk_slow = 1'b0;
    logic clr = 1'b1;
    always #5 clk_slow = ~clk_slow;

    vend_fsm_param_if #(.CREDIT_W(CW)) bus ();

    vend_fsm_param #(
        .CREDIT_W   (CW),
        .PRICE_A    (PA),
        .PRICE_B    (PB),
        .MAX_CREDIT (MAXC),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_slow(clk_slow),
        .clr     (clr),
        .bus     (bus)
    );

    typedef struct {
        int stamp;
        int val;
    } exp_t;

    // Event kinds: 0 vend(item), 1 change(amount), 2 nack, 3 coin_rej
    exp_t  q_ev[4][$];
    exp_t  q_credit[$];
    string ev_name[4] = '{"vend", "change", "nack", "coin_rej"};

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk_slow) cyc <= cyc + 1;

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference model: credit, how many edges the machine stays busy, change still owed.
    int m_credit, m_lock, m_owed, m_idle;

    task automatic model_reset();
        m_credit = 0; m_lock = 0; m_owed = 0; m_idle = 0;
        for (int k = 0; k < 4; k++) q_ev[k].delete();
        q_credit.delete();
    endtask

    task automatic model_step(int coin, int sel, int b, int c);
        int stamp = cyc + 1;
        int val = (coin == 1) ? 1 : (coin == 2) ? 2 : (coin == 3) ? 5 : 0;
        int price = sel ? PB : PA;
        bit timed_out = 1'b0;
        if (m_lock > 0) begin
            if (coin != 0) q_ev[3].push_back('{stamp, 1});
            if (m_owed > 0) begin
                q_ev[1].push_back('{stamp, m_owed});
                m_credit = 0;
                m_owed = 0;
            end
            m_lock--;
            m_idle = 0;
        end else begin
            if (b != 0 || c != 0 || coin != 0) m_idle = 0;
            else if (m_credit > 0) m_idle++;
            else m_idle = 0;
`ifdef VEND_TIMEOUT_EN
            timed_out = (m_idle == TO);
`endif
            if (timed_out) begin
                q_ev[1].push_back('{stamp, m_credit});
                m_credit = 0; m_lock = 1; m_idle = 0;
            end else if (c != 0) begin
                if (coin != 0) q_ev[3].push_back('{stamp, 1});
                if (m_credit > 0) begin
                    q_ev[1].push_back('{stamp, m_credit});
                    m_credit = 0; m_lock = 1;
                end
            end else if (b != 0) begin
                if (coin != 0) q_ev[3].push_back('{stamp, 1});
                if (m_credit >= price) begin
                    q_ev[0].push_back('{stamp, sel});
                    m_credit -= price;
                    m_owed = m_credit;
                    m_lock = (m_credit > 0) ? 2 : 1;
                end else begin
                    q_ev[2].push_back('{stamp, 1});
                end
            end else if (coin != 0) begin
                if (m_credit + val <= MAXC) m_credit += val;
                else q_ev[3].push_back('{stamp, 1});
            end
        end
        q_credit.push_back('{stamp, m_credit});
    endtask

    task automatic cycle(int coin, int sel, int b, int c);
        @(negedge clk_slow);
        #1;
        bus.coin     = 2'(coin);
        bus.item_sel = sel[0];
        bus.buy      = b[0];
        bus.cancel   = c[0];
        model_step(coin, sel, b, c);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    logic mon_sig[4];
    int   mon_val[4];

    always @(negedge clk_slow) begin
        if (!clr) begin
            if (q_credit.size() > 0 && q_credit[0].stamp == cyc) begin
                check("credit", int'(bus.credit), q_credit[0].val);
                void'(q_credit.pop_front());
            end
            mon_sig[0] = bus.vend;       mon_val[0] = int'(bus.item_out);
            mon_sig[1] = bus.change_vld; mon_val[1] = int'(bus.change);
            mon_sig[2] = bus.nack;       mon_val[2] = 1;
            mon_sig[3] = bus.coin_rej;   mon_val[3] = 1;
            for (int k = 0; k < 4; k++) begin
                while (q_ev[k].size() > 0 && q_ev[k][0].stamp < cyc) begin
                    check({ev_name[k], "_missing"}, 0, 1);
                    void'(q_ev[k].pop_front());
                end
                if (mon_sig[k]) begin
                    if (q_ev[k].size() > 0 && q_ev[k][0].stamp == cyc) begin
                        check(ev_name[k], mon_val[k], q_ev[k][0].val);
                        void'(q_ev[k].pop_front());
                    end else begin
                        check({ev_name[k], "_unexpected"}, 1, 0);
                    end
                end
            end
            if (!bus.change_vld) check("change_idle_zero", int'(bus.change), 0);
        end
    end

    initial begin
        bus.coin = 2'b00; bus.item_sel = 1'b0; bus.buy = 1'b0; bus.cancel = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_slow);
        check("rst_credit", int'(bus.credit), 0);
        check("rst_vend", int'(bus.vend), 0);
        check("rst_change_vld", int'(bus.change_vld), 0);
        check("rst_nack", int'(bus.nack), 0);
        check("rst_coin_rej", int'(bus.coin_rej), 0);
        #1 clr = 1'b0;

        // 1: 1+2 then buy A, exact price
        cycle(1, 0, 0, 0); cycle(2, 0, 0, 0); cycle(0, 0, 1, 0); idle(3);
        // 2: 5+2 then buy B, change 3
        cycle(3, 0, 0, 0); cycle(2, 0, 0, 0); cycle(0, 1, 1, 0); idle(3);
        // 3: credit 2, buy B refused, then cancel
        cycle(2, 0, 0, 0); cycle(0, 1, 1, 0); idle(1); cycle(0, 0, 0, 1); idle(2);
        // 4: credit 8, overflowing coin, then buy+cancel+coin together
        cycle(3, 0, 0, 0); cycle(2, 0, 0, 0); cycle(1, 0, 0, 0); cycle(2, 0, 0, 0);
        cycle(1, 1, 1, 1); idle(2);
        // cancel and buy with zero credit
        cycle(0, 0, 0, 1); cycle(0, 0, 1, 0); cycle(2, 0, 0, 1); idle(2);

        // 5: clr in the middle of CHANGE
        cycle(3, 0, 0, 0); cycle(2, 0, 0, 0); cycle(0, 1, 1, 0); cycle(0, 0, 0, 0);
        @(negedge clk_slow);
        check("pre_clr_change_vld", int'(bus.change_vld), 1);
        check("pre_clr_change", int'(bus.change), 3);
        #2 clr = 1'b1;
        #1;
        check("clr_change_vld", int'(bus.change_vld), 0);
        check("clr_change", int'(bus.change), 0);
        check("clr_credit", int'(bus.credit), 0);
        model_reset();
        @(negedge clk_slow);
        #1 clr = 1'b0;
        idle(2);
        check("post_clr_credit", int'(bus.credit), 0);
        cycle(1, 0, 0, 0); idle(1);

`ifdef VEND_TIMEOUT_EN
        // 6: credit 5 left alone until auto-refund
        cycle(0, 0, 0, 1); idle(1);
        cycle(3, 0, 0, 0); idle(18);
`endif

        for (int i = 0; i < 800; i++) begin
            if (i % 150 == 149) idle(20);
            else cycle(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                       int'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0) ? 1 : 0,
                       ($urandom_range(0, 19) == 0) ? 1 : 0);
        end
        idle(4);
        @(negedge clk_slow);
        #1;
        for (int k = 0; k < 4; k++) check({ev_name[k], "_leftover"}, q_ev[k].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
